// File: rtl/div_ctrl_pkg.sv
// Shared types and defaults for the two-client divider arbiter.
package div_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    BUSY = 2'd2
  } state_t;

  localparam int unsigned DEF_W       = 4;
  localparam int unsigned DEF_DIV_LAT = 4;

  // Wide enough for any practical W; users slice the low W bits.
  localparam logic [31:0] DZ_QUOT = '1;

endpackage

// File: rtl/div_arbiter_if.sv
// Request/response bundle between the two client datapaths and the arbiter.
interface div_arbiter_if
  import div_ctrl_pkg::*;
#(
  parameter int unsigned W = DEF_W
);

  logic         req0;
  logic         req1;
  logic [W-1:0] a0;
  logic [W-1:0] b0;
  logic [W-1:0] a1;
  logic [W-1:0] b1;
  logic         gnt0;
  logic         gnt1;
  logic         done0;
  logic         done1;
  logic [W-1:0] y0;
  logic [W-1:0] y1;
  logic         dz0;
  logic         dz1;
  logic         busy;

  modport master (
    output req0, req1, a0, b0, a1, b1,
    input  gnt0, gnt1, done0, done1, y0, y1, dz0, dz1, busy
  );

  modport slave (
    input  req0, req1, a0, b0, a1, b1,
    output gnt0, gnt1, done0, done1, y0, y1, dz0, dz1, busy
  );

endinterface

// File: rtl/div_arbiter_div.sv
// Restoring unsigned divider: one quotient bit per cycle, first bit on the ld edge.
module div #(
  parameter int unsigned W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         ld,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] y
);

  localparam int unsigned SW = $clog2(W + 1);

  logic [W-1:0]  r_rem;
  logic [W-1:0]  r_quo;
  logic [W-1:0]  r_dvs;
  logic [SW-1:0] r_steps;

  logic [W-1:0]  w_rem_in;
  logic [W-1:0]  w_quo_in;
  logic [W-1:0]  w_dvs;
  logic [W:0]    w_sh;
  logic          w_ge;
  logic [W-1:0]  w_rem_nx;
  logic [W-1:0]  w_quo_nx;
  logic          w_active;

  // The step on the ld edge reads operands straight from the ports.
  assign w_rem_in = ld ? '0 : r_rem;
  assign w_quo_in = ld ? a  : r_quo;
  assign w_dvs    = ld ? b  : r_dvs;
  assign w_sh     = {w_rem_in, w_quo_in[W-1]};
  assign w_ge     = (w_sh >= {1'b0, w_dvs});
  assign w_rem_nx = w_ge ? W'(w_sh - {1'b0, w_dvs}) : w_sh[W-1:0];
  assign w_quo_nx = {w_quo_in[W-2:0], w_ge};
  assign w_active = ld || (r_steps != '0);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_rem   <= '0;
      r_quo   <= '0;
      r_dvs   <= '0;
      r_steps <= '0;
    end else if (w_active) begin
      r_rem   <= w_rem_nx;
      r_quo   <= w_quo_nx;
      r_dvs   <= w_dvs;
      r_steps <= ld ? SW'(W - 1) : r_steps - 1'b1;
    end
  end

  assign y = r_quo;

endmodule

// File: rtl/div_arbiter.sv
// Round-robin arbiter sharing one sequential divider between two requesters,
// with divide-by-zero answered directly from IDLE.
module div_arbiter
  import div_ctrl_pkg::*;
#(
  parameter int unsigned W       = DEF_W,
  parameter int unsigned DIV_LAT = DEF_DIV_LAT
) (
  input logic          clk,
  input logic          rst,
  div_arbiter_if.slave bus
);

  localparam int unsigned CW = $clog2(DIV_LAT + 1);

  state_t        r_state, w_state_nx;
  logic          r_last,  w_last_nx;
  logic          r_win,   w_win_nx;
  logic [W-1:0]  r_ra,    w_ra_nx;
  logic [W-1:0]  r_rb,    w_rb_nx;
  logic [CW-1:0] r_cnt,   w_cnt_nx;
  logic          r_gnt0,  w_gnt0_nx;
  logic          r_gnt1,  w_gnt1_nx;
  logic          r_done0, w_done0_nx;
  logic          r_done1, w_done1_nx;
  logic [W-1:0]  r_y0,    w_y0_nx;
  logic [W-1:0]  r_y1,    w_y1_nx;
  logic          r_dz0,   w_dz0_nx;
  logic          r_dz1,   w_dz1_nx;
  logic          r_busy,  w_busy_nx;

  logic          w_pick1;
  logic [W-1:0]  w_a;
  logic [W-1:0]  w_b;
  logic          w_ld;
  logic [W-1:0]  w_q;

  // Under contention the requester that did not win last time goes next.
  assign w_pick1 = bus.req1 && (!bus.req0 || !r_last);
  assign w_a     = w_pick1 ? bus.a1 : bus.a0;
  assign w_b     = w_pick1 ? bus.b1 : bus.b0;
  assign w_ld    = (r_state == LOAD);

  div #(.W(W)) u_div (
    .clk (clk),
    .rst (rst),
    .ld  (w_ld),
    .a   (r_ra),
    .b   (r_rb),
    .y   (w_q)
  );

  always_comb begin
    w_state_nx = r_state;
    w_last_nx  = r_last;
    w_win_nx   = r_win;
    w_ra_nx    = r_ra;
    w_rb_nx    = r_rb;
    w_cnt_nx   = r_cnt;
    w_gnt0_nx  = 1'b0;
    w_gnt1_nx  = 1'b0;
    w_done0_nx = 1'b0;
    w_done1_nx = 1'b0;
    w_y0_nx    = r_y0;
    w_y1_nx    = r_y1;
    w_dz0_nx   = r_dz0;
    w_dz1_nx   = r_dz1;

    case (r_state)
      IDLE: begin
        if (bus.req0 || bus.req1) begin
          w_last_nx = w_pick1;
          w_win_nx  = w_pick1;
          if (w_pick1) w_gnt1_nx = 1'b1;
          else         w_gnt0_nx = 1'b1;
          if (w_b == '0) begin
            if (w_pick1) begin
              w_y1_nx    = DZ_QUOT[W-1:0];
              w_dz1_nx   = 1'b1;
              w_done1_nx = 1'b1;
            end else begin
              w_y0_nx    = DZ_QUOT[W-1:0];
              w_dz0_nx   = 1'b1;
              w_done0_nx = 1'b1;
            end
          end else begin
            w_ra_nx    = w_a;
            w_rb_nx    = w_b;
            w_state_nx = LOAD;
          end
        end
      end
      LOAD: begin
        w_cnt_nx   = '0;
        w_state_nx = BUSY;
      end
      BUSY: begin
        if (r_cnt == CW'(DIV_LAT - 1)) begin
          w_state_nx = IDLE;
          if (r_win) begin
            w_y1_nx    = w_q;
            w_dz1_nx   = 1'b0;
            w_done1_nx = 1'b1;
          end else begin
            w_y0_nx    = w_q;
            w_dz0_nx   = 1'b0;
            w_done0_nx = 1'b1;
          end
        end else begin
          w_cnt_nx = r_cnt + 1'b1;
        end
      end
      default: w_state_nx = IDLE;
    endcase

    w_busy_nx = (w_state_nx != IDLE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= IDLE;
      r_last  <= 1'b1;
      r_win   <= 1'b0;
      r_ra    <= '0;
      r_rb    <= '0;
      r_cnt   <= '0;
      r_gnt0  <= 1'b0;
      r_gnt1  <= 1'b0;
      r_done0 <= 1'b0;
      r_done1 <= 1'b0;
      r_y0    <= '0;
      r_y1    <= '0;
      r_dz0   <= 1'b0;
      r_dz1   <= 1'b0;
      r_busy  <= 1'b0;
    end else begin
      r_state <= w_state_nx;
      r_last  <= w_last_nx;
      r_win   <= w_win_nx;
      r_ra    <= w_ra_nx;
      r_rb    <= w_rb_nx;
      r_cnt   <= w_cnt_nx;
      r_gnt0  <= w_gnt0_nx;
      r_gnt1  <= w_gnt1_nx;
      r_done0 <= w_done0_nx;
      r_done1 <= w_done1_nx;
      r_y0    <= w_y0_nx;
      r_y1    <= w_y1_nx;
      r_dz0   <= w_dz0_nx;
      r_dz1   <= w_dz1_nx;
      r_busy  <= w_busy_nx;
    end
  end

  assign bus.gnt0  = r_gnt0;
  assign bus.gnt1  = r_gnt1;
  assign bus.done0 = r_done0;
  assign bus.done1 = r_done1;
  assign bus.y0    = r_y0;
  assign bus.y1    = r_y1;
  assign bus.dz0   = r_dz0;
  assign bus.dz1   = r_dz1;
  assign bus.busy  = r_busy;

endmodule

// File: tb/tb_div_arbiter.sv
// Bench for div_arbiter: directed table, corner sequences and random traffic
// checked against a transaction-timing model.
module tb_div_arbiter;

  localparam int unsigned W  = 4;
  localparam int unsigned DL = 4;
  localparam int unsigned OW = 2 * W + 7;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  div_arbiter_if #(.W(W)) bus ();

  div_arbiter #(.W(W), .DIV_LAT(DL)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_vec = 0;
  int n_bad = 0;

  // Model: edge counter, when the arbiter is next free, pending result.
  int           e       = 0;
  int           free_at = 0;
  int           busy_hi = -1;
  int           pd_at   = 0;
  bit           pd_valid = 1'b0;
  bit           pd_k     = 1'b0;
  logic [W-1:0] pd_y     = '0;
  bit           m_last   = 1'b1;
  logic [W-1:0] m_y[2]   = '{'0, '0};
  bit           m_dz[2]  = '{1'b0, 1'b0};
  bit           m_gnt[2] = '{1'b0, 1'b0};
  bit           m_done[2] = '{1'b0, 1'b0};

  task automatic model_edge(input bit r, input bit rq0, input logic [W-1:0] a0, input logic [W-1:0] b0,
                            input bit rq1, input logic [W-1:0] a1, input logic [W-1:0] b1);
    bit           k;
    logic [W-1:0] a, b;
    e++;
    m_gnt  = '{1'b0, 1'b0};
    m_done = '{1'b0, 1'b0};
    if (!r) begin
      m_last = 1'b1; pd_valid = 1'b0; busy_hi = -1; free_at = 0;
      m_y = '{'0, '0}; m_dz = '{1'b0, 1'b0};
      return;
    end
    if (pd_valid && e == pd_at) begin
      m_done[pd_k] = 1'b1; m_y[pd_k] = pd_y; m_dz[pd_k] = 1'b0; pd_valid = 1'b0;
    end
    if (e >= free_at && (rq0 || rq1)) begin
      k = (rq0 && rq1) ? !m_last : rq1;
      a = k ? a1 : a0;
      b = k ? b1 : b0;
      m_last = k;
      m_gnt[k] = 1'b1;
      if (b == 0) begin
        m_y[k] = '1; m_dz[k] = 1'b1; m_done[k] = 1'b1;
        free_at = e + 1;
      end else begin
        pd_valid = 1'b1; pd_k = k; pd_y = a / b; pd_at = e + DL + 1;
        busy_hi = e + DL;
        free_at = e + DL + 2;
      end
    end
  endtask

  function automatic logic [OW-1:0] dut_word();
    return {bus.gnt0, bus.gnt1, bus.done0, bus.done1, bus.y0, bus.y1, bus.dz0, bus.dz1, bus.busy};
  endfunction

  function automatic logic [OW-1:0] exp_word();
    return {m_gnt[0], m_gnt[1], m_done[0], m_done[1], m_y[0], m_y[1], m_dz[0], m_dz[1], (e <= busy_hi)};
  endfunction

  task automatic step(input bit r, input bit rq0, input logic [W-1:0] a0, input logic [W-1:0] b0,
                      input bit rq1, input logic [W-1:0] a1, input logic [W-1:0] b1, input string nm);
    logic [OW-1:0] got, want;
    rst = r; bus.req0 = rq0; bus.a0 = a0; bus.b0 = b0;
    bus.req1 = rq1; bus.a1 = a1; bus.b1 = b1;
    @(posedge clk);
    model_edge(r, rq0, a0, b0, rq1, a1, b1);
    @(negedge clk);
    got  = dut_word();
    want = exp_word();
    n_vec++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s edge %0d: {gnt0,gnt1,done0,done1,y0,y1,dz0,dz1,busy} got=%h expected=%h",
               nm, e, got, want);
    end
  endtask

  typedef struct {
    bit rq0; logic [3:0] a0, b0; bit rq1; logic [3:0] a1, b1;
    bit gnt0, gnt1, done0, done1; logic [3:0] y0, y1; bit dz0, dz1, busy, ld;
  } vec_t;

  vec_t tbl[19];

  bit           p0, p1;
  logic [W-1:0] ra0, rb0, ra1, rb1;
  logic [OW:0]  tgot, twant;

  initial begin
    rst = 1'b0;
    bus.req0 = 1'b0; bus.req1 = 1'b0;
    bus.a0 = '0; bus.b0 = '0; bus.a1 = '0; bus.b1 = '0;

    //        rq0 a0 b0 rq1 a1 b1  g0 g1 d0 d1 y0 y1 z0 z1 busy ld
    tbl[0]  = '{1, 11, 2, 0, 0, 0,  1, 0, 0, 0, 0,  0, 0, 0, 1, 1};
    tbl[1]  = '{0, 11, 2, 0, 0, 0,  0, 0, 0, 0, 0,  0, 0, 0, 1, 0};
    tbl[2]  = tbl[1];
    tbl[3]  = tbl[1];
    tbl[4]  = tbl[1];
    tbl[5]  = '{0, 0, 0, 0, 0, 0,   0, 0, 1, 0, 5,  0, 0, 0, 0, 0};
    tbl[6]  = '{0, 0, 0, 1, 9, 8,   0, 1, 0, 0, 5,  0, 0, 0, 1, 1};
    tbl[7]  = '{0, 0, 0, 0, 9, 8,   0, 0, 0, 0, 5,  0, 0, 0, 1, 0};
    tbl[8]  = tbl[7];
    tbl[9]  = tbl[7];
    tbl[10] = tbl[7];
    tbl[11] = '{0, 0, 0, 0, 0, 0,   0, 0, 0, 1, 5,  1, 0, 0, 0, 0};
    tbl[12] = '{0, 0, 0, 1, 6, 0,   0, 1, 0, 1, 5, 15, 0, 1, 0, 0};
    tbl[13] = '{1, 7, 3, 0, 0, 0,   1, 0, 0, 0, 5, 15, 0, 1, 1, 1};
    tbl[14] = '{0, 7, 3, 0, 0, 0,   0, 0, 0, 0, 5, 15, 0, 1, 1, 0};
    tbl[15] = tbl[14];
    tbl[16] = tbl[14];
    tbl[17] = tbl[14];
    tbl[18] = '{0, 0, 0, 0, 0, 0,   0, 0, 1, 0, 2, 15, 0, 1, 0, 0};

    step(0, 0, 0, 0, 0, 0, 0, "reset");
    step(0, 0, 0, 0, 0, 0, 0, "reset");

    for (int i = 0; i < 19; i++) begin
      step(1, tbl[i].rq0, tbl[i].a0, tbl[i].b0, tbl[i].rq1, tbl[i].a1, tbl[i].b1, "tbl_model");
      tgot  = {dut_word(), dut.w_ld};
      twant = {tbl[i].gnt0, tbl[i].gnt1, tbl[i].done0, tbl[i].done1, tbl[i].y0, tbl[i].y1,
               tbl[i].dz0, tbl[i].dz1, tbl[i].busy, tbl[i].ld};
      n_vec++;
      if (tgot !== twant) begin
        n_bad++;
        $display("FAIL tbl[%0d]: {outputs,ld} got=%h expected=%h", i, tgot, twant);
      end
    end

    // Continuous contention from reset: 0, 1, 0, ...
    step(0, 0, 0, 0, 0, 0, 0, "contend_rst");
    for (int i = 0; i < 20; i++) step(1, 1, 15, 3, 1, 14, 7, "contend");

    // Reset during the second BUSY cycle, then a fresh request.
    step(0, 0, 0, 0, 0, 0, 0, "midrst_pre");
    step(1, 1, 13, 2, 0, 0, 0, "midrst_e0");
    step(1, 0, 13, 2, 0, 0, 0, "midrst_busy1");
    step(1, 0, 13, 2, 0, 0, 0, "midrst_busy2");
    step(0, 0, 13, 2, 0, 0, 0, "midrst_assert");
    step(0, 0, 0, 0, 0, 0, 0, "midrst_hold");
    for (int i = 0; i < DL + 3; i++) step(1, 0, 0, 0, 0, 0, 0, "midrst_nodone");
    step(1, 1, 13, 2, 0, 0, 0, "midrst_fresh");
    for (int i = 0; i < DL + 2; i++) step(1, 0, 0, 0, 0, 0, 0, "midrst_result");

    // Operands change right after the grant; captured values must be used.
    step(1, 1, 14, 4, 0, 0, 0, "opchg_e0");
    step(1, 0, 1, 1, 0, 0, 0, "opchg_after");
    for (int i = 0; i < DL + 1; i++) step(1, 0, 2, 1, 0, 0, 0, "opchg_wait");

    p0 = 1'b0; p1 = 1'b0;
    ra0 = '0; rb0 = '0; ra1 = '0; rb1 = '0;
    for (int c = 0; c < 800; c++) begin
      if (!p0 && $urandom_range(0, 2) == 0) begin
        p0 = 1'b1; ra0 = W'($urandom);
        rb0 = ($urandom_range(0, 7) == 0) ? '0 : W'($urandom);
      end else if (p0 && $urandom_range(0, 31) == 0) p0 = 1'b0;
      if (!p1 && $urandom_range(0, 2) == 0) begin
        p1 = 1'b1; ra1 = W'($urandom);
        rb1 = ($urandom_range(0, 7) == 0) ? '0 : W'($urandom);
      end else if (p1 && $urandom_range(0, 31) == 0) p1 = 1'b0;
      if ($urandom_range(0, 199) == 0) begin
        step(0, p0, ra0, rb0, p1, ra1, rb1, "rand_rst");
        p0 = 1'b0; p1 = 1'b0;
      end else begin
        step(1, p0, p0 ? ra0 : W'($urandom), rb0, p1, p1 ? ra1 : W'($urandom), rb1, "rand");
        if (m_gnt[0]) p0 = 1'b0;
        if (m_gnt[1]) p1 = 1'b0;
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/div_arbiter.md
# div_arbiter

Controller that shares one sequential unsigned divider (`div`, ports clk/rst/ld/a/b/y) between two requesters. It arbitrates round-robin, captures the winner's operands, pulses `ld` into the divider and waits the divider's fixed latency. It then returns the quotient to the winner. Division by zero is short-circuited without starting the divider. It sits between the two client datapaths and the single `div` instance it owns.

## Interface
Parameters:
- W, 4, operand/quotient width (matches `div`)
- DIV_LAT, 4, cycles from the cycle after `ld` until `div.y` is valid

Ports:
- clk  in  1  clock, all flops on rising edge
- rst  in  1  asynchronous, active-low reset
- req0 / req1  in  1  request from requester 0 / 1; held until grant
- a0, b0 / a1, b1  in  W  dividend, divisor of requester 0 / 1; valid while reqN=1
- gnt0 / gnt1  out  1  one-cycle pulse: operands accepted
- done0 / done1  out  1  one-cycle pulse: yN/dzN updated
- y0 / y1  out  W  quotient, held until that requester's next done
- dz0 / dz1  out  1  divide-by-zero flag, held with yN
- busy  out  1  high while the divider is in use (LOAD or BUSY)

## Operation
- States: IDLE, LOAD, BUSY. Reset state is IDLE. Priority pointer `last` resets to 1, so requester 0 wins first.
- IDLE, no request: stay.
- IDLE, one or both requests: pick the winner k (a sole requester wins; if both request, k = the one not equal to `last`). Set `last`=k and pulse gntk.
  - If bk != 0: capture ak, bk into internal ra/rb and go to LOAD.
  - If bk == 0: set yk={W{1}}, dzk=1, and pulse donek together with gntk. Stay in IDLE and do not touch the divider.
- LOAD: drive div.ld=1 with ra/rb for exactly one cycle. Clear the counter and go to BUSY.
- BUSY: count DIV_LAT cycles. On the last cycle's edge, latch div.y into yk, clear dzk, pulse donek and return to IDLE.
- div.ld is 0 in all other states. div.a/div.b always show ra/rb.
- Arithmetic: unsigned floor quotient, W bits. No remainder output.
- After a grant the requester may drop reqN or change its operands freely. If reqN is still high at IDLE, it is a new request.
- A request withdrawn before its grant is ignored.
- The non-granted requester keeps its yN/dzN values unchanged.
- Reset, including mid-operation: go to IDLE and set `last`=1. All gnt/done/dz outputs, y0, y1, busy and ra/rb go to 0. The div instance gets the same rst, so any in-flight result is discarded and no done is issued.

## Timing
- All outputs are registered; none is combinational from inputs.
- E0 is the edge that samples reqk in IDLE:
  - gntk is high in the cycle after E0.
  - ld is high in the cycle after E0.
  - busy is high from E0 to E0+DIV_LAT+1.
  - donek and the new yk appear after edge E0+DIV_LAT+1.
- Back-to-back: the next grant is possible at E0+DIV_LAT+2. Throughput is one division per DIV_LAT+2 cycles.
- Divide-by-zero: gnt and done both appear after E0, and the next grant is possible at E0+1.
- Requests arriving during LOAD/BUSY wait, with no loss.
- Simultaneous requests are resolved by the rule above, which guarantees alternation under continuous contention.

## Structure
- Package `div_ctrl_pkg`:
  - state enum (IDLE, LOAD, BUSY)
  - default W, DIV_LAT
  - localparam DZ_QUOT = all-ones
- One sub-module: the existing `div`, instantiated once inside div_arbiter. Its rst is tied to div_arbiter rst.
- Counter width: $clog2(DIV_LAT+1).

## Test plan
- Reset then single request: req0, a0=1011, b0=0010. Expect gnt0 after E0, done0 after E0+5, y0=0101, dz0=0, busy for 5 cycles.
- Single request on the other port: req1, a1=1001, b1=1000. Expect y1=0001 after E0+5; y0 unchanged.
- Contention: after reset, req0 and req1 both held high (0→1111/0011, 1→1110/0111). Expect order 0 then 1, second grant at E0+6, y0=0101, y1=0010. Then 0 again if both are still requesting.
- Divide by zero: req1, b1=0. Expect gnt1 and done1 in the same cycle, y1=1111, dz1=1, ld never high, next grant possible one cycle later.
- Reset mid-op: drop rst in the 2nd BUSY cycle. Expect state IDLE, all outputs 0, no done pulse. A fresh request afterwards computes correctly.
- Operand change after grant: change a0/b0 in the cycle after gnt0. Expect the result to reflect the originally captured operands.
